// File: rtl/cache_scheduler.sv
// cache_scheduler: frame sequencer and round-robin read arbiter for the row
// cache FIFO. Paces column pushes, holds off pops until a prefetch depth is
// buffered, then shares pops between two PE requesters and tags each row
// leaving the cache with its owner and row index.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; counters hold last frame's values
// FILL   | pushing rows only, building up the prefetch depth
// STREAM | pushing and popping concurrently
// DRAIN  | all rows written; popping the remainder
// DONE   | one-cycle frame_done, then back to IDLE
module cache_scheduler #(
    parameter int IF_HEIGTH        = 34,
    parameter int ROW_CNT_WIDTH    = 6,
    parameter int CACHE_ADDR_WIDTH = 3,
    parameter int PREFETCH         = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clk_en,
    input  logic                        start,
    input  logic                        col_valid,
    output logic                        col_ready,
    output logic                        cache_push,
    output logic                        cache_pop,
    input  logic [CACHE_ADDR_WIDTH:0]   fifo_count,
    input  logic [1:0]                  req,
    output logic [1:0]                  grant,
    output logic                        rd_valid,
    output logic                        rd_id,
    output logic [ROW_CNT_WIDTH-1:0]    row_idx,
    output logic                        busy,
    output logic                        frame_done
);

    localparam int DEPTH = 1 << CACHE_ADDR_WIDTH;
    localparam logic [ROW_CNT_WIDTH-1:0]  ROWS       = ROW_CNT_WIDTH'(IF_HEIGTH);
    localparam logic [CACHE_ADDR_WIDTH:0] DEPTH_C    = (CACHE_ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [CACHE_ADDR_WIDTH:0] PREFETCH_C = (CACHE_ADDR_WIDTH + 1)'(PREFETCH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [ROW_CNT_WIDTH-1:0]   wr_cnt;
    logic [ROW_CNT_WIDTH-1:0]   rd_cnt;
    logic                       last;
    logic                       pop_ok;

    // State register; clk_en low freezes the sequencer in place
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else if (clk_en) begin
            state <= state_nxt;
        end
    end

    // Next-state decode; counters compared as they stand before the edge
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (start) state_nxt = S_FILL;
            S_FILL:   if ((fifo_count >= PREFETCH_C) || (wr_cnt == ROWS)) state_nxt = S_STREAM;
            S_STREAM: if (wr_cnt == ROWS) state_nxt = S_DRAIN;
            S_DRAIN:  if (rd_cnt == ROWS) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Push/pop qualification and round-robin grant; a same-cycle pop never frees a push slot
    always_comb begin
        cache_push = clk_en && col_valid
                     && ((state == S_FILL) || (state == S_STREAM))
                     && (wr_cnt < ROWS) && (fifo_count < DEPTH_C);
        pop_ok     = clk_en && ((state == S_STREAM) || (state == S_DRAIN))
                     && (fifo_count != '0) && (rd_cnt < ROWS);
        grant      = 2'b00;
        if (pop_ok) begin
            unique case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
        cache_pop  = |grant;
        col_ready  = cache_push;
        busy       = (state != S_IDLE);
        frame_done = (state == S_DONE);
    end

    // Row counters; qualification above keeps them from passing IF_HEIGTH
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else if (clk_en) begin
            if ((state == S_IDLE) && start) begin
                wr_cnt <= '0;
                rd_cnt <= '0;
            end else begin
                if (cache_push) wr_cnt <= wr_cnt + ROW_CNT_WIDTH'(1);
                if (cache_pop)  rd_cnt <= rd_cnt + ROW_CNT_WIDTH'(1);
            end
        end
    end

    // Read tag pipeline aligned with the FIFO's registered output, plus arbiter history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last     <= 1'b1;
            rd_valid <= 1'b0;
            rd_id    <= 1'b0;
            row_idx  <= '0;
        end else if (clk_en) begin
            rd_valid <= cache_pop;
            if (cache_pop) begin
                last    <= grant[1];
                rd_id   <= grant[1];
                row_idx <= rd_cnt;
            end
        end
    end

endmodule

// File: tb/tb_cache_scheduler.sv
// Self-checking bench for cache_scheduler: a behavioural frame model drives
// the FIFO occupancy and predicts every output each cycle, a vector table
// exercises the arbiter and push blocking, and frame-level checks confirm
// row order, ownership and the done pulse.
module tb_cache_scheduler;

    localparam int H     = 34;
    localparam int RW    = 6;
    localparam int CA    = 3;
    localparam int DEPTH = 8;
    localparam int PF    = 4;

    logic          clk = 1'b0;
    logic          rst_n, clk_en, start, col_valid;
    logic          col_ready, cache_push, cache_pop;
    logic [CA:0]   fifo_count;
    logic [1:0]    req, grant;
    logic          rd_valid, rd_id, busy, frame_done;
    logic [RW-1:0] row_idx;

    cache_scheduler #(
        .IF_HEIGTH(H), .ROW_CNT_WIDTH(RW), .CACHE_ADDR_WIDTH(CA), .PREFETCH(PF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start),
        .col_valid(col_valid), .col_ready(col_ready), .cache_push(cache_push),
        .cache_pop(cache_pop), .fifo_count(fifo_count), .req(req), .grant(grant),
        .rd_valid(rd_valid), .rd_id(rd_id), .row_idx(row_idx), .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    // reference model: phase 0 idle, 1 fill, 2 stream, 3 drain, 4 done
    int m_phase, m_wr, m_rd, m_last, m_rdv, m_rdid, m_row;
    int fifo_lvl;
    bit fc_force = 0;
    int fc_val = 0;
    int e_push, e_grant;

    int obs_rows[$];
    int obs_ids[$];
    int dut_done;
    int dut_pushes;

    typedef struct {
        int fc;
        int rq;
        int cv;
        int exp_grant;
        int exp_push;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_wr = 0; m_rd = 0; m_last = 1;
        m_rdv = 0; m_rdid = 0; m_row = 0; fifo_lvl = 0;
    endtask

    task automatic clear_obs();
        obs_rows.delete();
        obs_ids.delete();
        dut_done = 0;
        dut_pushes = 0;
    endtask

    // one clock cycle: inputs already set at the falling edge
    task automatic step();
        int fc, np, push, pop;
        fc = fc_force ? fc_val : fifo_lvl;
        fifo_count = (CA + 1)'(fc);
        #1;
        e_push = int'(clk_en && col_valid && (m_phase == 1 || m_phase == 2) && m_wr < H && fc < DEPTH);
        e_grant = 0;
        if (clk_en && (m_phase == 2 || m_phase == 3) && fc != 0 && m_rd < H) begin
            if (req == 2'b11) e_grant = (m_last != 0) ? 1 : 2;
            else              e_grant = int'(req);
        end
        if (chk_on) begin
            chk("cache_push", int'(cache_push), e_push);
            chk("col_ready", int'(col_ready), e_push);
            chk("grant", int'(grant), e_grant);
            chk("cache_pop", int'(cache_pop), int'(e_grant != 0));
            chk("rd_valid", int'(rd_valid), m_rdv);
            chk("rd_id", int'(rd_id), m_rdid);
            chk("row_idx", int'(row_idx), m_row);
            chk("busy", int'(busy), int'(m_phase != 0));
            chk("frame_done", int'(frame_done), int'(m_phase == 4));
        end
        if (rst_n && clk_en) begin
            if (rd_valid) begin
                obs_rows.push_back(int'(row_idx));
                obs_ids.push_back(int'(rd_id));
            end
            if (frame_done) dut_done++;
            if (cache_push) dut_pushes++;
        end
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (clk_en) begin
            push = e_push;
            pop  = (e_grant != 0) ? 1 : 0;
            np = m_phase;
            case (m_phase)
                0: if (start) np = 1;
                1: if (fc >= PF || m_wr == H) np = 2;
                2: if (m_wr == H) np = 3;
                3: if (m_rd == H) np = 4;
                default: np = 0;
            endcase
            m_rdv = pop;
            if (pop != 0) begin
                m_rdid = (e_grant == 2) ? 1 : 0;
                m_row  = m_rd;
                m_last = m_rdid;
            end
            if (m_phase == 0 && start) begin
                m_wr = 0;
                m_rd = 0;
            end else begin
                m_wr += push;
                m_rd += pop;
            end
            if (!fc_force) fifo_lvl += push - pop;
            m_phase = np;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int budget, input bit rnd);
        int n = 0;
        while (!(dut_done > 0 && m_phase == 0) && n < budget) begin
            if (rnd) begin
                clk_en    = ($urandom_range(0, 9) != 0);
                col_valid = ($urandom_range(0, 3) != 0);
                req       = 2'($urandom_range(0, 3));
                start     = ($urandom_range(0, 7) == 0);
            end
            step();
            n++;
        end
        start = 1'b0; clk_en = 1'b1;
        chk("frame_completes", int'(n < budget), 1);
    endtask

    // ids: 0 = all PE0, 1 = alternating from PE0, 2 = not checked
    task automatic check_rows(input string nm, input int ids);
        chk({nm, "_row_count"}, obs_rows.size(), H);
        for (int i = 0; i < obs_rows.size() && i < H; i++) begin
            chk({nm, "_row_order"}, obs_rows[i], i);
            if (ids == 0) chk({nm, "_rd_id"}, obs_ids[i], 0);
            if (ids == 1) chk({nm, "_rd_id_alt"}, obs_ids[i], i % 2);
        end
        chk({nm, "_done_pulses"}, dut_done, 1);
        chk({nm, "_busy_after"}, int'(busy), 0);
    endtask

    initial begin
        vecs[0]  = '{fc: 0, rq: 3, cv: 1, exp_grant: 0, exp_push: 1};
        vecs[1]  = '{fc: 8, rq: 3, cv: 1, exp_grant: 1, exp_push: 0};
        vecs[2]  = '{fc: 8, rq: 3, cv: 1, exp_grant: 2, exp_push: 0};
        vecs[3]  = '{fc: 3, rq: 2, cv: 0, exp_grant: 2, exp_push: 0};
        vecs[4]  = '{fc: 3, rq: 3, cv: 1, exp_grant: 1, exp_push: 1};
        vecs[5]  = '{fc: 5, rq: 1, cv: 1, exp_grant: 1, exp_push: 1};
        vecs[6]  = '{fc: 5, rq: 3, cv: 1, exp_grant: 2, exp_push: 1};
        vecs[7]  = '{fc: 1, rq: 0, cv: 1, exp_grant: 0, exp_push: 1};
        vecs[8]  = '{fc: 7, rq: 2, cv: 1, exp_grant: 2, exp_push: 1};
        vecs[9]  = '{fc: 8, rq: 0, cv: 1, exp_grant: 0, exp_push: 0};
        vecs[10] = '{fc: 8, rq: 3, cv: 0, exp_grant: 1, exp_push: 0};
        vecs[11] = '{fc: 2, rq: 3, cv: 1, exp_grant: 2, exp_push: 1};

        rst_n = 1'b0; clk_en = 1'b1; start = 1'b0; col_valid = 1'b0;
        req = 2'b00; fifo_count = '0;
        model_reset();
        clear_obs();
        @(negedge clk);
        step();
        step();
        chk_on = 1;
        rst_n = 1'b1;

        // reset state, with requests present in IDLE
        req = 2'b11;
        step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_row_idx", int'(row_idx), 0);
        chk("rst_grant_idle", int'(grant), 0);

        // prefetch fill with no requests, then FIFO full blocks pushes
        req = 2'b00; col_valid = 1'b1;
        clear_obs();
        pulse_start();
        for (int i = 0; i < 12; i++) step();
        chk("fill_pushes", dut_pushes, 8);
        #1;
        chk("fill_full_col_ready", int'(col_ready), 0);

        // arbiter and push-blocking vectors in STREAM with forced occupancy
        fc_force = 1;
        for (int i = 0; i < 12; i++) begin
            req = 2'(vecs[i].rq);
            col_valid = vecs[i].cv;
            fc_val = vecs[i].fc;
            fifo_count = (CA + 1)'(fc_val);
            #1;
            chk("vec_grant", int'(grant), vecs[i].exp_grant);
            chk("vec_push", int'(cache_push), vecs[i].exp_push);
            step();
        end
        fc_force = 0;

        // full frame, PE0 only
        do_reset();
        clear_obs();
        col_valid = 1'b1; req = 2'b01;
        pulse_start();
        run_to_done(400, 0);
        check_rows("pe0_frame", 0);

        // full frame, both requesting: strict alternation from PE0
        do_reset();
        clear_obs();
        req = 2'b11;
        pulse_start();
        run_to_done(400, 0);
        check_rows("rr_frame", 1);

        // clk_en low for 5 cycles mid-STREAM
        do_reset();
        clear_obs();
        req = 2'b01;
        pulse_start();
        for (int i = 0; i < 10; i++) step();
        clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_grant", int'(grant), 0);
            chk("hold_push", int'(cache_push), 0);
        end
        clk_en = 1'b1;
        run_to_done(400, 0);
        check_rows("clk_en_frame", 0);

        // reset at row 20, restart, and a start pulse while busy
        do_reset();
        clear_obs();
        pulse_start();
        for (int i = 0; i < 200 && obs_rows.size() < 21; i++) step();
        chk("row20_reached", int'(obs_rows.size() >= 21), 1);
        do_reset();
        clear_obs();
        chk("abort_busy", int'(busy), 0);
        pulse_start();
        for (int i = 0; i < 3; i++) step();
        pulse_start();
        run_to_done(400, 0);
        check_rows("restart_frame", 0);

        // randomized frames against the model
        for (int f = 0; f < 3; f++) begin
            clear_obs();
            clk_en = 1'b1;
            pulse_start();
            run_to_done(4000, 1);
            check_rows("random_frame", 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
